// File: rtl/comb_rank_seq.sv
// Sequential combination ranker: accepts K elements (largest first) and returns sum C(c_i, i).
// Optional order/range checking is enabled with the RANK_ORDER_CHECK_EN macro.
module comb_rank_seq #(
  parameter int N          = 16,
  parameter int K          = 4,
  parameter int ELEM_WIDTH = 4,
  parameter int RANK_WIDTH = 11
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [ELEM_WIDTH-1:0] in_elem,
  output logic                  rank_valid,
  input  logic                  rank_ready,
  output logic [RANK_WIDTH-1:0] rank,
  output logic                  err
);

  localparam int IDX_W    = $clog2(K + 1);
  localparam int DEPTH    = 2 ** ELEM_WIDTH;
  localparam int ROM_BITS = DEPTH * K * RANK_WIDTH;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ACC  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  function automatic longint binom(input int n, input int k);
    longint r;
    if (k > n || k < 0) begin
      r = 64'sd0;
    end else begin
      r = 64'sd1;
      for (int j = 0; j < k; j++) begin
        r = r * longint'(n - j) / longint'(j + 1);
      end
    end
    return r;
  endfunction

  // Rows beyond N-1 repeat the table so an out-of-range index wraps modulo N.
  function automatic logic [ROM_BITS-1:0] build_rom();
    logic [ROM_BITS-1:0] t;
    t = '0;
    for (int c = 0; c < DEPTH; c++) begin
      for (int i = 1; i <= K; i++) begin
        t[(c * K + i - 1) * RANK_WIDTH +: RANK_WIDTH] = RANK_WIDTH'(binom(c % N, i));
      end
    end
    return t;
  endfunction

  localparam logic [ROM_BITS-1:0] ROM = build_rom();

  function automatic logic [RANK_WIDTH-1:0] rom_lookup(
    input logic [ELEM_WIDTH-1:0] e,
    input logic [IDX_W-1:0]      i
  );
    logic [RANK_WIDTH-1:0] v;
    int                    base;
    if (i == '0 || int'(i) > K) begin
      v = '0;
    end else begin
      base = (int'(e) * K + int'(i) - 1) * RANK_WIDTH;
      v    = ROM[base +: RANK_WIDTH];
    end
    return v;
  endfunction

  state_t                r_state;
  state_t                w_state_nxt;
  logic [RANK_WIDTH-1:0] r_acc;
  logic [IDX_W-1:0]      r_idx;
  logic                  r_rank_valid;
  logic                  w_in_ready;
  logic                  w_xfer;
  logic [IDX_W-1:0]      w_sel_i;
  logic [RANK_WIDTH-1:0] w_rom_val;
  logic [RANK_WIDTH-1:0] w_sum;

  assign w_xfer = in_valid & w_in_ready;
  assign w_sum  = r_acc + w_rom_val;

  // The first element of a frame uses weight K; later ones use the running index.
  always_comb begin
    w_sel_i = r_idx;
    if (r_state == S_IDLE) begin
      w_sel_i = IDX_W'(K);
    end else begin
      w_sel_i = r_idx;
    end
  end

`ifdef RANK_ORDER_CHECK_EN
  localparam logic [ELEM_WIDTH:0] N_EXT = (ELEM_WIDTH + 1)'(N);

  logic                  r_err;
  logic [ELEM_WIDTH-1:0] r_prev;
  logic                  w_oob;
  logic                  w_bad;

  assign w_oob = ({1'b0, in_elem} >= N_EXT);
  assign w_bad = w_oob | ((r_state == S_ACC) & (in_elem >= r_prev));

  // Out-of-range elements contribute nothing to the rank when checking is on.
  always_comb begin
    w_rom_val = '0;
    if (w_oob) begin
      w_rom_val = '0;
    end else begin
      w_rom_val = rom_lookup(in_elem, w_sel_i);
    end
  end

  // Sticky error flag lives for one frame, cleared when the result is taken.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err  <= 1'b0;
      r_prev <= '0;
    end else if (flush) begin
      r_err  <= 1'b0;
      r_prev <= '0;
    end else if (r_state == S_DONE && rank_ready) begin
      r_err  <= 1'b0;
    end else if (w_xfer) begin
      r_err  <= r_err | w_bad;
      r_prev <= in_elem;
    end
  end

  assign err = r_err;
`else
  // Table rows wrap, so any element value indexes a defined entry.
  always_comb begin
    w_rom_val = '0;
    w_rom_val = rom_lookup(in_elem, w_sel_i);
  end

  assign err = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state decode; flush wins over every handshake.
  always_comb begin
    w_state_nxt = r_state;
    if (flush) begin
      w_state_nxt = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_xfer) begin
            w_state_nxt = (K == 1) ? S_DONE : S_ACC;
          end else begin
            w_state_nxt = S_IDLE;
          end
        end
        S_ACC: begin
          if (w_xfer && r_idx == IDX_W'(1)) begin
            w_state_nxt = S_DONE;
          end else begin
            w_state_nxt = S_ACC;
          end
        end
        S_DONE: begin
          if (rank_ready) begin
            w_state_nxt = S_IDLE;
          end else begin
            w_state_nxt = S_DONE;
          end
        end
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  // Input ready decode.
  always_comb begin
    w_in_ready = 1'b0;
    if (!rst_n || flush) begin
      w_in_ready = 1'b0;
    end else begin
      case (r_state)
        S_IDLE:  w_in_ready = 1'b1;
        S_ACC:   w_in_ready = 1'b1;
        S_DONE:  w_in_ready = 1'b0;
        default: w_in_ready = 1'b0;
      endcase
    end
  end

  // Accumulator, index and registered result-valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc        <= '0;
      r_idx        <= IDX_W'(K);
      r_rank_valid <= 1'b0;
    end else if (flush) begin
      r_acc        <= '0;
      r_idx        <= IDX_W'(K);
      r_rank_valid <= 1'b0;
    end else begin
      r_rank_valid <= (w_state_nxt == S_DONE);
      case (r_state)
        S_IDLE: begin
          if (w_xfer) begin
            r_acc <= w_rom_val;
            r_idx <= IDX_W'(K - 1);
          end
        end
        S_ACC: begin
          if (w_xfer) begin
            r_acc <= w_sum;
            r_idx <= r_idx - IDX_W'(1);
          end
        end
        S_DONE: begin
          if (rank_ready) begin
            r_idx <= IDX_W'(K);
          end
        end
        default: begin
          r_acc <= '0;
          r_idx <= IDX_W'(K);
        end
      endcase
    end
  end

  assign in_ready   = w_in_ready;
  assign rank_valid = r_rank_valid;
  assign rank       = r_acc;

endmodule

// File: tb/tb_comb_rank_seq.sv
// Scoreboard bench for comb_rank_seq: reference ranks come from a Pascal table,
// directed frames plus randomized frames with random gaps and backpressure.
module tb_comb_rank_seq;

  localparam int N  = 16;
  localparam int K  = 4;
  localparam int EW = 4;
  localparam int RW = 11;

  typedef struct {
    int rank;
    int err;
  } exp_t;

  logic          clk;
  logic          rst_n;
  logic          flush;
  logic          in_valid;
  logic          in_ready;
  logic [EW-1:0] in_elem;
  logic          rank_valid;
  logic          rank_ready;
  logic [RW-1:0] rank;
  logic          err;

  int   n_cmp;
  int   n_fail;
  int   rr_mode;
  int   pas [0:N-1][0:K];
  exp_t sb[$];

  comb_rank_seq #(.N(N), .K(K), .ELEM_WIDTH(EW), .RANK_WIDTH(RW)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_elem(in_elem), .rank_valid(rank_valid), .rank_ready(rank_ready), .rank(rank),
    .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  function automatic exp_t model(input int e[K]);
    exp_t r;
    int   s;
    s     = 0;
    r.err = 0;
    for (int j = 0; j < K; j++) begin
      s += pas[e[j]][K - j];
`ifdef RANK_ORDER_CHECK_EN
      if (e[j] >= N || (j > 0 && e[j] >= e[j-1])) r.err = 1;
`endif
    end
    r.rank = s % (1 << RW);
    return r;
  endfunction

  task automatic send_elem(input int e);
    int ok;
    int t;
    t        = 0;
    ok       = 0;
    in_valid = 1'b1;
    in_elem  = EW'(e);
    while (ok == 0 && t < 200) begin
      @(negedge clk);
      ok = int'(in_ready);
      cycle();
      t++;
    end
    if (ok == 0) begin
      n_cmp++;
      n_fail++;
      $display("FAIL in_ready_timeout: got 0 expected 1");
    end
    in_valid = 1'b0;
  endtask

  task automatic send_frame(input int e[K], input int gap, input bit push);
    if (push) sb.push_back(model(e));
    for (int j = 0; j < K; j++) begin
      send_elem(e[j]);
      if (j < K - 1) repeat (gap) cycle();
    end
  endtask

  // Result-ready generator: always, random, or held low.
  initial begin
    rank_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (rr_mode)
        0:       rank_ready = 1'b1;
        1:       rank_ready = ($urandom_range(0, 2) != 0);
        default: rank_ready = 1'b0;
      endcase
    end
  end

  // Monitor: pops on every accepted result and checks hold stability under backpressure.
  initial begin
    bit        hold;
    int        prev_rank;
    int        prev_err;
    exp_t      x;
    hold = 1'b0;
    forever begin
      @(negedge clk);
      if (hold) begin
        check("hold_valid", int'(rank_valid), 1);
        check("hold_rank", int'(rank), prev_rank);
        check("hold_err", int'(err), prev_err);
      end
      hold      = rst_n && !flush && rank_valid && !rank_ready;
      prev_rank = int'(rank);
      prev_err  = int'(err);
      if (rst_n && !flush && rank_valid && rank_ready) begin
        if (sb.size() == 0) begin
          check("unexpected_result", 1, 0);
        end else begin
          x = sb.pop_front();
          check("rank", int'(rank), x.rank);
          check("err", int'(err), x.err);
        end
      end
    end
  end

  initial begin
    int e[K];
    int need;
    int t;
    int exp_err_bad;
    n_cmp    = 0;
    n_fail   = 0;
    rr_mode  = 0;
    rst_n    = 1'b0;
    flush    = 1'b0;
    in_valid = 1'b0;
    in_elem  = '0;
    for (int n = 0; n < N; n++) begin
      for (int k = 0; k <= K; k++) begin
        if (k == 0) pas[n][k] = 1;
        else if (n == 0) pas[n][k] = 0;
        else pas[n][k] = pas[n-1][k-1] + pas[n-1][k];
      end
    end

    repeat (3) cycle();
    check("rst_in_ready", int'(in_ready), 0);
    check("rst_rank_valid", int'(rank_valid), 0);
    check("rst_rank", int'(rank), 0);
    check("rst_err", int'(err), 0);
    rst_n = 1'b1;
    cycle();
    check("idle_in_ready", int'(in_ready), 1);

    // Minimum subset and latency.
    e = '{3, 2, 1, 0};
    send_frame(e, 0, 1'b1);
    check("latency_valid", int'(rank_valid), 1);
    check("done_in_ready", int'(in_ready), 0);
    check("direct_rank_0", int'(rank), 0);

    e = '{15, 14, 13, 12}; send_frame(e, 0, 1'b1);
    check("direct_rank_1819", int'(rank), 1819);
    e = '{4, 2, 1, 0};     send_frame(e, 0, 1'b1);
    check("direct_rank_1", int'(rank), 1);

    // Backpressure for five cycles.
    rr_mode = 2;
    cycle();
    e = '{7, 5, 2, 0};
    send_frame(e, 0, 1'b1);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check("bp_valid", int'(rank_valid), 1);
      check("bp_rank", int'(rank), 46);
      check("bp_in_ready", int'(in_ready), 0);
    end
    rr_mode = 0;
    cycle();

    // Stalls between elements.
    e = '{9, 6, 3, 1};
    send_frame(e, 3, 1'b1);
    check("gap_rank_150", int'(rank), 150);

    // Flush mid-frame, with in_valid asserted during the flush.
    send_elem(9);
    send_elem(6);
    in_valid = 1'b1;
    in_elem  = EW'(3);
    flush    = 1'b1;
    @(negedge clk);
    check("flush_in_ready", int'(in_ready), 0);
    cycle();
    flush    = 1'b0;
    in_valid = 1'b0;
    check("flush_no_valid", int'(rank_valid), 0);
    e = '{3, 2, 1, 0};
    send_frame(e, 0, 1'b1);

    // Reset mid-frame.
    send_elem(9);
    send_elem(6);
    rst_n = 1'b0;
    #1;
    check("midrst_in_ready", int'(in_ready), 0);
    cycle();
    check("midrst_rank", int'(rank), 0);
    rst_n = 1'b1;
    cycle();
    e = '{3, 2, 1, 0};
    send_frame(e, 0, 1'b1);
    check("midrst_rank_0", int'(rank), 0);

    // Order checking: repeated element, then a clean frame.
`ifdef RANK_ORDER_CHECK_EN
    exp_err_bad = 1;
`else
    exp_err_bad = 0;
`endif
    e = '{5, 5, 1, 0};
    send_frame(e, 0, 1'b1);
    check("order_err", int'(err), exp_err_bad);
    e = '{8, 3, 2, 0};
    send_frame(e, 0, 1'b1);
    check("order_err_cleared", int'(err), 0);

    // Randomized frames with random gaps and backpressure.
    rr_mode = 1;
    for (int f = 0; f < 40; f++) begin
      if ($urandom_range(0, 4) == 0) begin
        for (int j = 0; j < K; j++) e[j] = $urandom_range(0, N - 1);
      end else begin
        need = K;
        for (int c = N - 1; c >= 0; c--) begin
          if (need > 0 && $urandom_range(0, c) < need) begin
            e[K - need] = c;
            need--;
          end
        end
      end
      send_frame(e, $urandom_range(0, 2), 1'b1);
    end

    rr_mode = 0;
    t = 0;
    while (sb.size() != 0 && t < 200) begin
      cycle();
      t++;
    end
    check("scoreboard_drained", sb.size(), 0);
    repeat (2) cycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
